convergence_monitor: RTL

- Synthesizable, parametrised monitor for N signed signals: platform angle, platform rate, wheel rates.
- On each trigger it:
  - waits a settle interval;
  - captures each channel's magnitude;
  - waits an observation window;
  - checks each channel against an absolute error limit and, optionally, against strict decay.
- Used in self-checking benches and as an on-chip health checker in Segway digital core. Drives a fault LED/piezo path from a sticky fail count.

---
 rtl/conv_mon_pkg.sv | 37 +++
 rtl/conv_mon_timer.sv | 28 ++
 rtl/convergence_monitor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/conv_mon_pkg.sv
// Shared types and helpers for the convergence monitor: FSM states, the
// saturating absolute-value function and default constants.
package conv_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_WINDOW,
        ST_EVAL
    } state_t;

    localparam int          MAX_W         = 64;
    localparam logic [15:0] DEF_ERR_LIMIT = 16'h0800;

    // Magnitude of the w-bit two's-complement value in the low bits of v.
    // The most-negative code clamps to the largest positive code instead of wrapping.
    function automatic logic [MAX_W-1:0] abs_sat(input logic [MAX_W-1:0] v, input int unsigned w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] min_neg;
        logic [MAX_W-1:0] x;
        mask    = (MAX_W'(1) << w) - MAX_W'(1);
        min_neg = MAX_W'(1) << (w - 1);
        x       = v & mask;
        if ((x & min_neg) == '0)
            abs_sat = x;
        else if (x == min_neg)
            abs_sat = min_neg - MAX_W'(1);
        else
            abs_sat = (~x + MAX_W'(1)) & mask;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        sat_inc8 = (c == 8'hFF) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/conv_mon_timer.sv
// Loadable down-counter with a zero flag; reused for the settle and window intervals.
module conv_mon_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/convergence_monitor.sv
// Trigger-driven settle/capture/window/evaluate checker for NCH signed channels,
// with absolute-limit and strict-decay tests and saturating result counters.
module convergence_monitor
    import conv_mon_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               NCH       = 4,
    parameter int               SETTLE    = 100000,
    parameter int               WINDOW    = 800000,
    parameter logic [WIDTH-1:0] ERR_LIMIT = WIDTH'(DEF_ERR_LIMIT),
    parameter int               CNT_W     = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NCH*WIDTH-1:0] val,
    input  logic [NCH-1:0]       lim_mask,
    input  logic [NCH-1:0]       dec_mask,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NCH-1:0]       fail_ch,
    output logic [7:0]           chk_cnt,
    output logic [7:0]           fail_cnt
);

    if (SETTLE < 1 || SETTLE > (2 ** CNT_W) - 1) begin : g_bad_settle
        $error("convergence_monitor: SETTLE does not fit in CNT_W bits");
    end
    if (WINDOW < 1 || WINDOW > (2 ** CNT_W) - 1) begin : g_bad_window
        $error("convergence_monitor: WINDOW does not fit in CNT_W bits");
    end

    state_t           state_q;
    state_t           state_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;
    logic             cap_en;
    logic             eval_en;
    logic [NCH-1:0]   fail_next;

    conv_mon_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        cap_en   = 1'b0;
        eval_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(SETTLE - 1);
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) state_d = ST_CAPTURE;
                else          tmr_dec = 1'b1;
            end
            ST_CAPTURE: begin
                cap_en   = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(WINDOW - 1);
                state_d  = ST_WINDOW;
            end
            ST_WINDOW: begin
                if (tmr_zero) state_d = ST_EVAL;
                else          tmr_dec = 1'b1;
            end
            ST_EVAL: begin
                eval_en = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over everything, including a same-cycle evaluation.
        if (abort && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
            cap_en   = 1'b0;
            eval_en  = 1'b0;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] mag_end;
        logic [WIDTH-1:0] mag_cap;

        assign mag_end = WIDTH'(abs_sat(MAX_W'(val[i*WIDTH +: WIDTH]), WIDTH));

        // NOTE: the capture register is reset like any other state so a
        // decay check can never compare against power-up garbage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                mag_cap <= '0;
            else if (cap_en)
                mag_cap <= mag_end;
        end

        assign fail_next[i] = (lim_mask[i] && (mag_end >= ERR_LIMIT))
                            | (dec_mask[i] && (mag_end >= mag_cap));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass     <= 1'b0;
            fail_ch  <= '0;
            chk_cnt  <= '0;
            fail_cnt <= '0;
        end else if (eval_en) begin
            pass    <= ~|fail_next;
            fail_ch <= fail_next;
            chk_cnt <= sat_inc8(chk_cnt);
            if (|fail_next)
                fail_cnt <= sat_inc8(fail_cnt);
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = eval_en;

endmodule
